// File: rtl/av_sprite_pkg.sv
// rtl/av_sprite_pkg.sv - shared constants and types for the sprite fetch arbiter
package av_sprite_pkg;

    localparam int N_REQ = 6;
    localparam int AW    = 10;
    localparam int SPR_W = 13;
    localparam int N_SPR = 16;

    typedef logic [2:0]    req_id_t;
    typedef logic [3:0]    spr_idx_t;
    typedef logic [AW-1:0] spr_addr_t;

endpackage

// File: rtl/av_rr_pick.sv
// rtl/av_rr_pick.sv - combinational rotating-priority picker
module av_rr_pick
    import av_sprite_pkg::*;
#(
    parameter int N = N_REQ
)
(
    input  logic [N-1:0] req,
    input  req_id_t      ptr,
    output logic [N-1:0] gnt,
    output req_id_t      idx,
    output logic         any
);

    logic [3:0] cand;

    // Scan from ptr upward with wrap; the first requester found wins
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N)) begin
                cand = cand - 4'(N);
            end
            if (!any && req[cand[2:0]]) begin
                any            = 1'b1;
                idx            = cand[2:0];
                gnt[cand[2:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/av_sprite_fetch_arbiter.sv
// rtl/av_sprite_fetch_arbiter.sv - round-robin scheduler for the shared sprite BRAM port
module av_sprite_fetch_arbiter
    import av_sprite_pkg::*;
#(
    parameter int MAX_WAIT = 8
)
(
    input  logic                   clk65,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*4-1:0]     req_spr,
    output logic [N_REQ-1:0]       gnt,
    output logic [AW-1:0]          mem_addr,
    input  logic [N_SPR*SPR_W-1:0] mem_data,
    output logic [SPR_W-1:0]       rdata,
    output logic                   rvalid,
    output logic [2:0]             rid,
    output logic [N_REQ-1:0]       starve,
    input  logic                   starve_clr
);

    localparam int            CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    req_id_t          ptr;
    logic [N_REQ-1:0] pick_gnt;
    req_id_t          pick_idx;
    logic             pick_any;

    logic             s1_valid;
    req_id_t          s1_id;
    spr_idx_t         s1_spr;
    logic             s2_valid;
    req_id_t          s2_id;
    spr_idx_t         s2_spr;

    logic [CW-1:0]    wait_cnt [N_REQ];

    av_rr_pick #(.N(N_REQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant is visible in the request cycle but never while held in reset
    always_comb begin
        gnt = rst_n ? pick_gnt : '0;
    end

    // Grant side: advance pointer, latch BRAM address and load stage 1
    always_ff @(posedge clk65 or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            mem_addr <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_spr   <= '0;
        end else begin
            s1_valid <= pick_any;
            if (pick_any) begin
                ptr      <= (pick_idx == req_id_t'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                mem_addr <= req_addr[int'(pick_idx)*AW +: AW];
                s1_id    <= pick_idx;
                s1_spr   <= req_spr[int'(pick_idx)*4 +: 4];
            end
        end
    end

    // Stage 2 tracks the BRAM read latency, then the output register selects the sprite word
    always_ff @(posedge clk65 or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_spr   <= '0;
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_spr   <= s1_spr;
            rvalid   <= s2_valid;
            rid      <= s2_id;
            rdata    <= mem_data[int'(s2_spr)*SPR_W +: SPR_W];
        end
    end

    // Per-requester wait counters and sticky starve flags; a new set beats the clear
    always_ff @(posedge clk65 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            starve <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (wait_cnt[i] != WMAX) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
                starve[i] <= (starve[i] & ~starve_clr) | (wait_cnt[i] == WMAX);
            end
        end
    end

endmodule
